// File: rtl/v2_queue_arb_pkg.sv
// v2_queue_arb_pkg
//   Shared types for the queue arbiter: queue operation encoding, the
//   arbiter FSM state type and a helper that sizes requester index fields.
package v2_queue_arb_pkg;

  typedef enum logic [1:0] {
    ENQ_BACK  = 2'b00,
    ENQ_FRONT = 2'b01,
    DEQ_BACK  = 2'b10,
    DEQ_FRONT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    CHECK = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Width of a requester index; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Dequeue ops carry data back from the queue.
  function automatic logic is_deq(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/v2_queue_arb_if.sv
// v2_queue_arb_if
//   Bundles the per-requester request/response handshakes and the queue-side
//   op/completion signals of v2_queue_arb.
//   Requester side (arrays [p_num_reqs]):
//     req_val/req_op/req_data in, req_rdy out, resp_val/resp_data/resp_err
//     out, resp_rdy in.
//   Queue side: enq/deq front/back req pulses and enq data out, cpl and deq
//     data in.
//   Modports: master = arbiter view, slave = requesters + queue view.
interface v2_queue_arb_if #(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_bitwidth = 32
);

  logic                  req_val   [p_num_reqs];
  logic                  req_rdy   [p_num_reqs];
  logic [1:0]            req_op    [p_num_reqs];
  logic [p_bitwidth-1:0] req_data  [p_num_reqs];

  logic                  resp_val  [p_num_reqs];
  logic                  resp_rdy  [p_num_reqs];
  logic [p_bitwidth-1:0] resp_data [p_num_reqs];
  logic                  resp_err  [p_num_reqs];

  logic                  enq_back_req;
  logic                  enq_front_req;
  logic                  deq_back_req;
  logic                  deq_front_req;
  logic [p_bitwidth-1:0] enq_back_data;
  logic [p_bitwidth-1:0] enq_front_data;
  logic                  enq_back_cpl;
  logic                  enq_front_cpl;
  logic                  deq_back_cpl;
  logic                  deq_front_cpl;
  logic [p_bitwidth-1:0] deq_back_data;
  logic [p_bitwidth-1:0] deq_front_data;

  modport master (
    input  req_val, req_op, req_data, resp_rdy,
    output req_rdy, resp_val, resp_data, resp_err,
    output enq_back_req, enq_front_req, deq_back_req, deq_front_req,
    output enq_back_data, enq_front_data,
    input  enq_back_cpl, enq_front_cpl, deq_back_cpl, deq_front_cpl,
    input  deq_back_data, deq_front_data
  );

  modport slave (
    output req_val, req_op, req_data, resp_rdy,
    input  req_rdy, resp_val, resp_data, resp_err,
    input  enq_back_req, enq_front_req, deq_back_req, deq_front_req,
    input  enq_back_data, enq_front_data,
    output enq_back_cpl, enq_front_cpl, deq_back_cpl, deq_front_cpl,
    output deq_back_data, deq_front_data
  );

endinterface

// File: rtl/v2_rr_arbiter.sv
// v2_rr_arbiter
//   Combinational rotating-priority encoder. Grants the first set bit of
//   i_req at or after i_ptr, wrapping to index 0.
//   Ports:
//     i_req  [p_num_reqs]  request vector
//     i_ptr  [p_ptr_w]     highest-priority index
//     o_gnt  [p_num_reqs]  one-hot grant (all zero when no request)
//     o_idx  [p_ptr_w]     index of the granted requester
//     o_any               some request is granted
module v2_rr_arbiter
  import v2_queue_arb_pkg::*;
#(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_ptr_w    = ptr_width(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] i_req,
  input  logic [p_ptr_w-1:0]    i_ptr,
  output logic [p_num_reqs-1:0] o_gnt,
  output logic [p_ptr_w-1:0]    o_idx,
  output logic                  o_any
);

  // Two passes instead of a modulo walk: indices >= ptr first, then the
  // wrapped indices below ptr.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (!o_any && (i >= 32'(i_ptr)) && i_req[i]) begin
        o_any    = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = p_ptr_w'(i);
      end
    end
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (!o_any && (i < 32'(i_ptr)) && i_req[i]) begin
        o_any    = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = p_ptr_w'(i);
      end
    end
  end

endmodule

// File: rtl/v2_queue_arb.sv
// v2_queue_arb
//   Arbitrates p_num_reqs requesters onto a single double-ended queue. One
//   operation in flight: grant (IDLE) -> one-cycle op pulse (ISSUE) ->
//   completion sample (CHECK) -> response held until taken (RESP).
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset; also gates req_rdy, resp_val and
//          the queue req pulses low combinationally
//     bus  v2_queue_arb_if.master (requester handshakes + queue side)
//   Build option:
//     V2_QUEUE_ARB_RETRY_EN  retry a failed op up to p_max_retries times
//                            before reporting resp_err.
module v2_queue_arb
  import v2_queue_arb_pkg::*;
#(
  parameter int unsigned p_num_reqs    = 4,
  parameter int unsigned p_bitwidth    = 32,
  parameter int unsigned p_max_retries = 3
) (
  input  logic           clk,
  input  logic           rst,
  v2_queue_arb_if.master bus
);

  localparam int unsigned PW = ptr_width(p_num_reqs);

  state_e                r_state;
  state_e                w_next;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_owner;
  op_e                   r_op;
  logic [p_bitwidth-1:0] r_data;
  logic [p_bitwidth-1:0] r_resp_data;
  logic                  r_resp_err;

  logic [p_num_reqs-1:0] w_req_vec;
  logic [p_num_reqs-1:0] w_gnt;
  logic [PW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_cpl;
  logic [p_bitwidth-1:0] w_deq_data;
  logic                  w_retry;
  logic                  w_issue;
  logic                  w_taken;

`ifdef V2_QUEUE_ARB_RETRY_EN
  localparam int unsigned RW = (p_max_retries > 0) ? $clog2(p_max_retries + 1) : 1;
  localparam logic [RW-1:0] MAX_RETRY = RW'(p_max_retries);
  logic [RW-1:0] r_retry;
`endif

  always_comb begin
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      w_req_vec[i] = bus.req_val[i];
    end
  end

  v2_rr_arbiter #(
    .p_num_reqs (p_num_reqs),
    .p_ptr_w    (PW)
  ) u_arb (
    .i_req (w_req_vec),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Completion and return data for the latched op only; other cpl lines
  // are don't-care.
  always_comb begin
    w_cpl      = 1'b0;
    w_deq_data = '0;
    case (r_op)
      ENQ_BACK:  w_cpl = bus.enq_back_cpl;
      ENQ_FRONT: w_cpl = bus.enq_front_cpl;
      DEQ_BACK:  begin
        w_cpl      = bus.deq_back_cpl;
        w_deq_data = bus.deq_back_data;
      end
      DEQ_FRONT: begin
        w_cpl      = bus.deq_front_cpl;
        w_deq_data = bus.deq_front_data;
      end
      default: ;
    endcase
  end

`ifdef V2_QUEUE_ARB_RETRY_EN
  always_comb w_retry = !w_cpl && (r_retry < MAX_RETRY);
`else
  always_comb w_retry = 1'b0;
`endif

  always_comb w_taken = bus.resp_rdy[r_owner];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = CHECK;
      CHECK:   w_next = w_retry ? ISSUE : RESP;
      RESP:    if (w_taken) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_op        <= ENQ_BACK;
      r_data      <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
`ifdef V2_QUEUE_ARB_RETRY_EN
      r_retry     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_idx;
            r_op    <= op_e'(bus.req_op[w_idx]);
            r_data  <= bus.req_data[w_idx];
`ifdef V2_QUEUE_ARB_RETRY_EN
            r_retry <= '0;
`endif
          end
        end
        CHECK: begin
          if (w_cpl) begin
            r_resp_data <= is_deq(r_op) ? w_deq_data : '0;
            r_resp_err  <= 1'b0;
          end else if (w_retry) begin
`ifdef V2_QUEUE_ARB_RETRY_EN
            r_retry <= r_retry + 1'b1;
`endif
          end else begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (w_taken) begin
            r_ptr <= (32'(r_owner) == p_num_reqs - 1) ? '0 : r_owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_issue            = !rst && (r_state == ISSUE);
    bus.enq_back_req   = w_issue && (r_op == ENQ_BACK);
    bus.enq_front_req  = w_issue && (r_op == ENQ_FRONT);
    bus.deq_back_req   = w_issue && (r_op == DEQ_BACK);
    bus.deq_front_req  = w_issue && (r_op == DEQ_FRONT);
    bus.enq_back_data  = r_data;
    bus.enq_front_data = r_data;
  end

  always_comb begin
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      bus.req_rdy[i]   = !rst && (r_state == IDLE) && w_gnt[i];
      bus.resp_val[i]  = !rst && (r_state == RESP) && (r_owner == PW'(i));
      bus.resp_data[i] = (r_owner == PW'(i)) ? r_resp_data : '0;
      bus.resp_err[i]  = (r_owner == PW'(i)) && r_resp_err;
    end
  end

endmodule

// File: tb/tb_v2_queue_arb.sv
// tb_v2_queue_arb
//   Directed bench for v2_queue_arb with a behavioural deque (capacity 8)
//   answering the queue side one cycle after each op pulse.
//   Expected values follow V2_QUEUE_ARB_RETRY_EN when it is defined.
module tb_v2_queue_arb;
  import v2_queue_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned BW = 32;
  localparam int unsigned MR = 3;

`ifdef V2_QUEUE_ARB_RETRY_EN
  localparam int EMPTY_LAT    = 9;
  localparam int EMPTY_PULSES = MR + 1;
`else
  localparam int EMPTY_LAT    = 3;
  localparam int EMPTY_PULSES = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  v2_queue_arb_if #(.p_num_reqs(NR), .p_bitwidth(BW)) bus();

  v2_queue_arb #(
    .p_num_reqs    (NR),
    .p_bitwidth    (BW),
    .p_max_retries (MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural deque
  logic [BW-1:0] mq[$];
  logic          m_ebc, m_efc, m_dbc, m_dfc;
  logic [BW-1:0] m_dbd, m_dfd;
  logic          inj_cpl;

  always @(posedge clk) begin
    m_ebc <= 1'b0; m_efc <= 1'b0; m_dbc <= 1'b0; m_dfc <= 1'b0;
    m_dbd <= '0;   m_dfd <= '0;
    if (rst) begin
      mq.delete();
    end else begin
      if (bus.enq_back_req && mq.size() < 8) begin
        mq.push_back(bus.enq_back_data);  m_ebc <= 1'b1;
      end
      if (bus.enq_front_req && mq.size() < 8) begin
        mq.push_front(bus.enq_front_data); m_efc <= 1'b1;
      end
      if (bus.deq_back_req && mq.size() > 0) begin
        m_dbd <= mq.pop_back();  m_dbc <= 1'b1;
      end
      if (bus.deq_front_req && mq.size() > 0) begin
        m_dfd <= mq.pop_front(); m_dfc <= 1'b1;
      end
    end
  end

  assign bus.enq_back_cpl   = m_ebc;
  assign bus.enq_front_cpl  = m_efc;
  assign bus.deq_back_cpl   = m_dbc;
  assign bus.deq_front_cpl  = m_dfc | inj_cpl;
  assign bus.deq_back_data  = m_dbd;
  assign bus.deq_front_data = m_dfd;

  // Monitor: op pulses and grants, sampled mid-cycle
  int            n_eb = 0, n_ef = 0, n_db = 0, n_df = 0;
  time           t_eb, t_acc;
  logic [BW-1:0] d_eb, d_ef;
  int            gnt_q[$];
  time           gnt_t[$];

  always begin
    int hot;
    @(negedge clk); #1;
    if (bus.enq_back_req)  begin n_eb++; t_eb = $time; d_eb = bus.enq_back_data; end
    if (bus.enq_front_req) begin n_ef++; d_ef = bus.enq_front_data; end
    if (bus.deq_back_req)  n_db++;
    if (bus.deq_front_req) n_df++;
    hot = 0;
    for (int i = 0; i < NR; i++) begin
      if (bus.req_rdy[i]) begin
        hot++;
        gnt_q.push_back(i);
        gnt_t.push_back($time);
      end
    end
    if (hot != 0) chk("gnt_onehot", 32'(hot), 1);
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // One full transaction with resp_rdy already high; latency counted from
  // the accept cycle to the first resp_val cycle.
  task automatic do_op(input string tag, input int r, input logic [1:0] op,
                       input logic [BW-1:0] d, input logic [BW-1:0] exp_d,
                       input logic exp_e, input int exp_lat);
    int n;
    int cyc;
    @(negedge clk);
    bus.req_val[r] = 1'b1; bus.req_op[r] = op; bus.req_data[r] = d;
    bus.resp_rdy[r] = 1'b1;
    #1;
    n = 0;
    while (!bus.req_rdy[r] && n < 20) begin @(negedge clk); #1; n++; end
    chk({tag, ":gnt"}, 32'(bus.req_rdy[r]), 1);
    t_acc = $time;
    @(negedge clk); bus.req_val[r] = 1'b0; #1;
    cyc = 1;
    while (!bus.resp_val[r] && cyc < 40) begin @(negedge clk); #1; cyc++; end
    chk({tag, ":lat"},  32'(cyc), 32'(exp_lat));
    chk({tag, ":data"}, bus.resp_data[r], exp_d);
    chk({tag, ":err"},  32'(bus.resp_err[r]), 32'(exp_e));
    @(negedge clk); bus.resp_rdy[r] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int eb0, ef0, db0, df0, n, seen;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1; inj_cpl = 1'b0;
    for (int i = 0; i < NR; i++) begin
      bus.req_val[i] = 1'b0; bus.req_op[i] = 2'b00;
      bus.req_data[i] = '0;  bus.resp_rdy[i] = 1'b0;
    end

    // Reset gating and post-reset state
    @(negedge clk); @(negedge clk);
    bus.req_val[0] = 1'b1; #1;
    chk("rst_req_rdy", 32'(bus.req_rdy[0]), 0);
    bus.req_val[0] = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_resp_val",  32'(bus.resp_val[0]), 0);
    chk("idle_resp_data", bus.resp_data[0], 0);
    chk("idle_resp_err",  32'(bus.resp_err[0]), 0);
    chk("idle_enq_req",   32'(bus.enq_back_req), 0);

    // Single enqueue
    eb0 = n_eb; ef0 = n_ef; db0 = n_db; df0 = n_df;
    do_op("enq_a5", 0, ENQ_BACK, 32'hA5, 32'h0, 1'b0, 3);
    chk("enq_a5:pulses", 32'(n_eb - eb0), 1);
    chk("enq_a5:cycle",  32'((t_eb - t_acc) / 10), 1);
    chk("enq_a5:qdata",  d_eb, 32'hA5);
    chk("enq_a5:other",  32'((n_ef - ef0) + (n_db - db0) + (n_df - df0)), 0);

    // Dequeue ordering
    do_reset();
    do_op("enq_11", 0, ENQ_BACK,  32'h11, 32'h0,  1'b0, 3);
    do_op("enq_22", 0, ENQ_BACK,  32'h22, 32'h0,  1'b0, 3);
    do_op("deq_f",  1, DEQ_FRONT, 32'h0,  32'h11, 1'b0, 3);
    do_op("deq_b",  1, DEQ_BACK,  32'h0,  32'h22, 1'b0, 3);

    // Empty reject
    db0 = n_db;
    do_op("empty", 2, DEQ_BACK, 32'h0, 32'h0, 1'b1, EMPTY_LAT);
    chk("empty:pulses", 32'(n_db - db0), 32'(EMPTY_PULSES));

    // Front enqueue ordering
    do_op("enqf_33", 3, ENQ_FRONT, 32'h33, 32'h0, 1'b0, 3);
    do_op("enqf_44", 3, ENQ_FRONT, 32'h44, 32'h0, 1'b0, 3);
    chk("enqf:qdata", d_ef, 32'h44);
    do_op("deqf_44", 0, DEQ_FRONT, 32'h0, 32'h44, 1'b0, 3);
    do_op("deqb_33", 0, DEQ_BACK,  32'h0, 32'h33, 1'b0, 3);

    // Fairness with all requesters active
    do_reset();
    gnt_q.delete(); gnt_t.delete();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      bus.req_val[i] = 1'b1; bus.req_op[i] = ENQ_BACK;
      bus.req_data[i] = 32'(i + 1); bus.resp_rdy[i] = 1'b1;
    end
    n = 0;
    while (gnt_q.size() < 5 && n < 80) begin @(negedge clk); n++; end
    for (int i = 0; i < NR; i++) bus.req_val[i] = 1'b0;
    chk("fair:count", 32'(gnt_q.size() >= 5), 1);
    for (int k = 0; k < 5; k++) begin
      if (k < gnt_q.size()) chk("fair:order", 32'(gnt_q[k]), 32'(exp_order[k]));
      if (k > 0 && k < gnt_q.size()) chk("fair:spacing", 32'((gnt_t[k] - gnt_t[k-1]) / 10), 4);
    end
    repeat (6) @(negedge clk);
    for (int i = 0; i < NR; i++) bus.resp_rdy[i] = 1'b0;

    // Backpressure, with a stray completion during RESP
    do_reset();
    do_op("bp_enq", 1, ENQ_BACK, 32'h77, 32'h0, 1'b0, 3);
    @(negedge clk);
    bus.req_val[1] = 1'b1; bus.req_op[1] = DEQ_FRONT; bus.resp_rdy[1] = 1'b0; #1;
    chk("bp:gnt", 32'(bus.req_rdy[1]), 1);
    @(negedge clk);
    bus.req_val[1] = 1'b0;
    bus.req_val[0] = 1'b1; bus.req_op[0] = ENQ_BACK; bus.req_data[0] = 32'h55;
    bus.resp_rdy[0] = 1'b1; #1;
    n = 0;
    while (!bus.resp_val[1] && n < 20) begin @(negedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      chk("bp:resp_val",  32'(bus.resp_val[1]), 1);
      chk("bp:resp_data", bus.resp_data[1], 32'h77);
      chk("bp:no_rdy",    32'(bus.req_rdy[0]), 0);
      inj_cpl = (k == 1);
      @(negedge clk); #1;
    end
    inj_cpl = 1'b0;
    chk("bp:held_data", bus.resp_data[1], 32'h77);
    bus.resp_rdy[1] = 1'b1; #1;
    chk("bp:no_rdy_last", 32'(bus.req_rdy[0]), 0);
    @(negedge clk); #1;
    chk("bp:next_gnt",  32'(bus.req_rdy[0]), 1);
    chk("bp:resp_done", 32'(bus.resp_val[1]), 0);
    bus.resp_rdy[1] = 1'b0;
    @(negedge clk); bus.req_val[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus.resp_rdy[0] = 1'b0;

    // Reset in CHECK; pointer was 1 before the reset
    @(negedge clk);
    bus.req_val[2] = 1'b1; bus.req_op[2] = ENQ_BACK; bus.req_data[2] = 32'h99;
    bus.resp_rdy[2] = 1'b1; #1;
    n = 0;
    while (!bus.req_rdy[2] && n < 20) begin @(negedge clk); #1; n++; end
    chk("rmid:gnt", 32'(bus.req_rdy[2]), 1);
    @(negedge clk); bus.req_val[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.req_val[0] = 1'b1; bus.req_op[0] = ENQ_BACK; bus.req_data[0] = 32'h66;
    bus.req_val[2] = 1'b1; bus.resp_rdy[0] = 1'b1; #1;
    chk("rmid:qreqs", 32'({bus.enq_back_req, bus.enq_front_req,
                           bus.deq_back_req, bus.deq_front_req}), 0);
    chk("rmid:resp_val", 32'(bus.resp_val[2]), 0);
    @(negedge clk); #1;
    chk("rmid:rdy_gated", 32'({bus.req_rdy[0], bus.req_rdy[2]}), 0);
    rst = 1'b0; #1;
    chk("rmid:gnt0", 32'(bus.req_rdy[0]), 1);
    chk("rmid:no_gnt2", 32'(bus.req_rdy[2]), 0);
    @(negedge clk);
    bus.req_val[0] = 1'b0; bus.req_val[2] = 1'b0;
    seen = 0; n = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.resp_val[2]) seen++;
      if (bus.resp_val[0]) n++;
      @(negedge clk);
    end
    chk("rmid:no_resp2", 32'(seen), 0);
    chk("rmid:resp0",    32'(n), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/v2_queue_arb.md
V2_QUEUE_ARB -- requirements
Module: v2_queue_arb

Interface
REQ-001 SHALL take parameters: p_num_reqs, default 4, number of requesters; p_bitwidth, default 32, data width; p_max_retries, default 3, retry limit (used only with V2_QUEUE_ARB_RETRY_EN).
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-003 SHALL provide per-requester ports as unpacked arrays [p_num_reqs]: req_val  input  1  request valid; req_rdy  output  1  request accepted this cycle; req_op  input  2  operation code; req_data  input  p_bitwidth  enqueue data.
REQ-004 SHALL provide per-requester responses: resp_val  output  1  response valid; resp_rdy  input  1  response taken; resp_data  output  p_bitwidth  dequeued data (0 for enqueues); resp_err  output  1  operation rejected (queue full or empty).
REQ-005 SHALL drive the queue side: enq_back_req, enq_front_req, deq_back_req, deq_front_req  output  1  one-cycle op pulse; enq_back_data, enq_front_data  output  p_bitwidth  enqueue data; enq_back_cpl, enq_front_cpl, deq_back_cpl, deq_front_cpl  input  1  completion; deq_back_data, deq_front_data  input  p_bitwidth  dequeued data.

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, CHECK, RESP; reset state IDLE.
REQ-007 In IDLE, SHALL grant the first asserted req_val at or after the rotating priority pointer, assert req_rdy for the winner only in that cycle, latch owner/op/data, and move to ISSUE; with no req_val it stays in IDLE.
REQ-008 In ISSUE, SHALL assert exactly one queue req line, the one selected by the latched op, for exactly one cycle, with the matching enq data driven; then move to CHECK.
REQ-009 In CHECK, SHALL treat the cpl matching the latched op as success; on success it captures deq data (deq ops) or 0 (enq ops), clears resp_err, and moves to RESP.
REQ-010 In CHECK with the matching cpl low, SHALL set resp_err=1 and resp_data=0 and move to RESP (retry behaviour per REQ-016).
REQ-011 In RESP, SHALL hold resp_val high for the owner only, with resp_data/resp_err stable, until resp_rdy is high; on that cycle it moves to IDLE and sets the priority pointer to (owner+1) mod p_num_reqs.
REQ-012 SHALL keep all queue req lines low outside ISSUE and all req_rdy low outside IDLE; at most one operation is in flight.
REQ-013 Minimum latency SHALL be: accept at cycle 0, issue at 1, check at 2, resp_val at 3; back-to-back grants are spaced at least 4 cycles apart.
REQ-014 Non-owner resp_val SHALL be 0; cpl pulses arriving outside CHECK SHALL be ignored.

Reset
REQ-015 While rst is high, SHALL force every queue req line, req_rdy and resp_val to 0 combinationally; on the next edge it sets state IDLE, priority pointer 0, resp_data 0, resp_err 0 and retry count 0. Reset mid-operation abandons the operation with no response.

Configuration
REQ-016 With V2_QUEUE_ARB_RETRY_EN defined, a CHECK failure while retry count < p_max_retries SHALL increment the count and return to ISSUE; error is reported only after p_max_retries+1 failed attempts, and the count clears on each grant. Without the macro there is no retry counter and the first failure reports an error.

Structure
REQ-017 SHALL place the op encoding (ENQ_BACK=2'b00, ENQ_FRONT=2'b01, DEQ_BACK=2'b10, DEQ_FRONT=2'b11) and FSM state typedef in package v2_queue_arb_pkg.
REQ-018 SHALL implement winner selection in sub-module v2_rr_arbiter (combinational rotating-priority encoder: req vector and pointer in, one-hot grant out).

Verification
REQ-019 Single enq: requester 0 enq_back 0xA5 on an empty queue -> enq_back_req pulses at cycle 1 only; resp_val at cycle 3, resp_err=0, resp_data=0.
REQ-020 Deq: after enq 0x11 then 0x22 (both enq_back), requester 1 deq_front -> resp_data=0x11, resp_err=0; then deq_back -> 0x22.
REQ-021 Empty reject: deq_back on an empty queue -> resp_err=1, resp_data=0 at cycle 3 (no macro); with macro and p_max_retries=3 -> 4 deq_back_req pulses, resp_err=1 at cycle 9.
REQ-022 Fairness: all 4 requesters hold req_val -> grants occur in order 0,1,2,3,0, each resp_rdy held high.
REQ-023 Backpressure: resp_rdy held low 5 cycles -> resp_val and resp_data stable, no new req_rdy until resp_rdy=1.
REQ-024 Reset mid-op: rst asserted in CHECK -> same-cycle queue reqs, req_rdy and resp_val low; after reset no response, and the next grant goes to requester 0.
